// File: rtl/conv_dot_unit_pkg.sv
// Shared constants, layer codes, dot FSM states and the output saturation helper
// for the first 3x3 convolution stage.
package conv_dot_unit_pkg;
    localparam int DATA_LEN  = 18;
    localparam int FRAC      = 10;
    localparam int N_CH      = 32;
    localparam int IN_H      = 5;
    localparam int IN_W      = 6;
    localparam int OUT_H     = 3;
    localparam int OUT_W     = 4;
    localparam int N_POS     = OUT_H * OUT_W;
    localparam int KW        = 3;
    localparam int KK        = KW * KW;
    localparam int N_ROWS    = N_CH * N_POS;
    localparam int RAM_DEPTH = 512;
    localparam int ADDR_W    = 9;
    localparam int ACC_W     = 32;
    localparam int PROD_W    = 2 * DATA_LEN;
    localparam int SAT_MAX   = 2 ** (DATA_LEN - 1) - 1;
    localparam int SAT_MIN   = -(2 ** (DATA_LEN - 1));
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

    typedef enum logic [3:0] {
        LIDLE  = 4'd0,
        LAYER1 = 4'd1,
        LAYER2 = 4'd2,
        LAYER3 = 4'd3
    } layer_e;

    typedef enum logic [1:0] {
        DOT_IDLE,
        DOT_RUN,
        DOT_DRAIN,
        DOT_DONE
    } dot_state_e;

    function automatic logic [DATA_LEN-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return DATA_LEN'(SAT_MAX);
        else if (v < SAT_MIN)
            return DATA_LEN'(SAT_MIN);
        else
            return v[DATA_LEN-1:0];
    endfunction
endpackage

// File: rtl/conv_dot_unit_dot.sv
// Dot pass: streams 384 window rows, MACs each against 32x9 weights into 12x32 accumulators;
// dot_valid rises 387 cycles after start, q saturated at that point and held afterwards.
module dot
    import conv_dot_unit_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_dot_load,
    input  logic                          i_im_load,
    input  logic [3:0]                    i_cs,
    output logic [ADDR_W-1:0]             o_addr,
    input  logic [KK*DATA_LEN-1:0]        i_rdat,
    output logic [4:0]                    o_w_addr,
    input  logic [N_CH*KK*DATA_LEN-1:0]   i_w_data,
    output logic                          o_dot_valid,
    output logic [N_POS*N_CH*DATA_LEN-1:0] o_q
);
    dot_state_e               r_state;
    logic [ADDR_W-1:0]        r_cnt;
    logic                     r_rd_vld;
    logic [3:0]               r_pos;
    logic [4:0]               r_w_addr;
    logic                     r_dot_valid;
    logic [N_POS*N_CH*DATA_LEN-1:0] r_q;
    logic signed [ACC_W-1:0]  r_acc [N_POS][N_CH];
    logic signed [ACC_W-1:0]  w_sum [N_CH];

    always_comb begin
        logic signed [PROD_W-1:0] prod;
        prod = '0;
        for (int o = 0; o < N_CH; o++) begin
            w_sum[o] = '0;
            for (int k = 0; k < KK; k++) begin
                prod = $signed(i_rdat[k*DATA_LEN +: DATA_LEN]) *
                       $signed(i_w_data[(o*KK+k)*DATA_LEN +: DATA_LEN]);
                w_sum[o] = w_sum[o] + ACC_W'(prod >>> FRAC);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= DOT_IDLE;
            r_cnt       <= '0;
            r_rd_vld    <= 1'b0;
            r_pos       <= '0;
            r_w_addr    <= '0;
            r_dot_valid <= 1'b0;
            r_q         <= '0;
            for (int p = 0; p < N_POS; p++)
                for (int o = 0; o < N_CH; o++)
                    r_acc[p][o] <= '0;
        end else begin
            r_rd_vld <= 1'b0;
            if (r_rd_vld)
                for (int o = 0; o < N_CH; o++)
                    r_acc[r_pos][o] <= r_acc[r_pos][o] + w_sum[o];
            if (!i_dot_load) begin
                r_state     <= DOT_IDLE;
                r_cnt       <= '0;
                r_dot_valid <= 1'b0;
            end else begin
                case (r_state)
                    DOT_IDLE: if (i_cs != LIDLE && !i_im_load) begin
                        r_state <= DOT_RUN;
                        r_cnt   <= '0;
                        r_q     <= '0;
                        for (int p = 0; p < N_POS; p++)
                            for (int o = 0; o < N_CH; o++)
                                r_acc[p][o] <= '0;
                    end
                    DOT_RUN: begin
                        r_rd_vld <= 1'b1;
                        r_w_addr <= 5'(r_cnt / ADDR_W'(N_POS));
                        r_pos    <= 4'(r_cnt % ADDR_W'(N_POS));
                        if (r_cnt == LAST_ROW) begin
                            r_state <= DOT_DRAIN;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    // Two cycles let the last RAM read land and accumulate.
                    DOT_DRAIN: begin
                        if (r_cnt == ADDR_W'(1)) begin
                            r_state     <= DOT_DONE;
                            r_dot_valid <= 1'b1;
                            for (int p = 0; p < N_POS; p++)
                                for (int o = 0; o < N_CH; o++)
                                    r_q[(p*N_CH+o)*DATA_LEN +: DATA_LEN] <= sat(r_acc[p][o]);
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                    default: r_state <= DOT_DONE;
                endcase
            end
        end
    end

    assign o_addr      = r_cnt;
    assign o_w_addr    = r_w_addr;
    assign o_dot_valid = r_dot_valid;
    assign o_q         = r_q;
endmodule

// File: rtl/conv_dot_unit_im2col.sv
// im2col fill: one 3x3 window row per cycle into the window RAM, rows 0..383;
// im_valid rises on the cycle the last row is written and holds until im_load drops.
module im2col
    import conv_dot_unit_pkg::*;
(
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_im_load,
    input  logic [N_CH*IN_H*IN_W*DATA_LEN-1:0] i_d,
    output logic                         o_we,
    output logic [ADDR_W-1:0]            o_addr,
    output logic [KK*DATA_LEN-1:0]       o_wdat,
    output logic                         o_im_valid
);
    logic [ADDR_W-1:0] r_cnt;
    logic              r_im_valid;
    int                w_ch;
    int                w_pos;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_im_valid <= 1'b0;
        end else if (!i_im_load) begin
            r_cnt      <= '0;
            r_im_valid <= 1'b0;
        end else if (!r_im_valid) begin
            if (r_cnt == LAST_ROW)
                r_im_valid <= 1'b1;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Row a = ch*12 + r*4 + c; element ky*3+kx comes from d[ch][r+ky][c+kx].
    always_comb begin
        o_wdat = '0;
        w_ch   = int'(r_cnt) / N_POS;
        w_pos  = int'(r_cnt) % N_POS;
        for (int ky = 0; ky < KW; ky++) begin
            for (int kx = 0; kx < KW; kx++) begin
                o_wdat[(ky*KW+kx)*DATA_LEN +: DATA_LEN] =
                    i_d[((w_ch*IN_H + w_pos/OUT_W + ky)*IN_W + w_pos%OUT_W + kx)*DATA_LEN +: DATA_LEN];
            end
        end
    end

    assign o_we       = i_im_load & ~r_im_valid;
    assign o_addr     = r_cnt;
    assign o_im_valid = r_im_valid;
endmodule

// File: rtl/conv_dot_unit_window_ram.sv
// Single-port window RAM, 512 x 9 elements; synchronous write, registered read
// (one cycle latency); contents are not reset.
module window_ram
    import conv_dot_unit_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [KK*DATA_LEN-1:0] i_wdat,
    output logic [KK*DATA_LEN-1:0] o_rdat
);
    logic [KK*DATA_LEN-1:0] r_mem [RAM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdat;
        o_rdat <= r_mem[i_addr];
    end
endmodule

// File: rtl/conv_dot_unit.sv
// First 3x3 conv stage: im2col fill into window RAM, then dot pass over 32 output channels.
// RAM port belongs to the fill while im_load is high, otherwise to the dot pass.
module conv_dot_unit
    import conv_dot_unit_pkg::*;
(
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_im_load,
    input  logic [N_CH*IN_H*IN_W*DATA_LEN-1:0]  i_d,
    input  logic                                i_dot_load,
    input  logic [3:0]                          i_cs,
    output logic [4:0]                          o_w_addr,
    input  logic [N_CH*KK*DATA_LEN-1:0]         i_w_data,
    output logic                                o_im_valid,
    output logic                                o_dot_valid,
    output logic [N_POS*N_CH*DATA_LEN-1:0]      o_q
);
    logic                   w_we;
    logic [ADDR_W-1:0]      w_fill_addr;
    logic [ADDR_W-1:0]      w_dot_addr;
    logic [ADDR_W-1:0]      w_ram_addr;
    logic [KK*DATA_LEN-1:0] w_wdat;
    logic [KK*DATA_LEN-1:0] w_rdat;

    assign w_ram_addr = i_im_load ? w_fill_addr : w_dot_addr;

    im2col u_im2col (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_im_load  (i_im_load),
        .i_d        (i_d),
        .o_we       (w_we),
        .o_addr     (w_fill_addr),
        .o_wdat     (w_wdat),
        .o_im_valid (o_im_valid)
    );

    window_ram u_window_ram (
        .i_clk  (i_clk),
        .i_we   (w_we),
        .i_addr (w_ram_addr),
        .i_wdat (w_wdat),
        .o_rdat (w_rdat)
    );

    dot u_dot (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_dot_load  (i_dot_load),
        .i_im_load   (i_im_load),
        .i_cs        (i_cs),
        .o_addr      (w_dot_addr),
        .i_rdat      (w_rdat),
        .o_w_addr    (o_w_addr),
        .i_w_data    (i_w_data),
        .o_dot_valid (o_dot_valid),
        .o_q         (o_q)
    );
endmodule

// File: tb/tb_conv_dot_unit.sv
// Directed + randomized bench for conv_dot_unit against a direct convolution model.
module tb_conv_dot_unit;
    localparam int DL = 18;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 im_load;
    logic                 dot_load;
    logic [3:0]           cs;
    logic [32*30*DL-1:0]  d_bus;
    logic [32*9*DL-1:0]   w_bus;
    logic [4:0]           w_addr;
    logic                 im_valid;
    logic                 dot_valid;
    logic [12*32*DL-1:0]  q;

    logic [DL-1:0] D [32][5][6];
    logic [DL-1:0] W [32][32][9];
    logic [DL-1:0] exp_q [12][32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_dot_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_im_load   (im_load),
        .i_d         (d_bus),
        .i_dot_load  (dot_load),
        .i_cs        (cs),
        .o_w_addr    (w_addr),
        .i_w_data    (w_bus),
        .o_im_valid  (im_valid),
        .o_dot_valid (dot_valid),
        .o_q         (q)
    );

    always_comb begin
        d_bus = '0;
        for (int ch = 0; ch < 32; ch++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 6; x++)
                    d_bus[(ch*30+y*6+x)*DL +: DL] = D[ch][y][x];
    end

    always_comb begin
        w_bus = '0;
        for (int o = 0; o < 32; o++)
            for (int k = 0; k < 9; k++)
                w_bus[(o*9+k)*DL +: DL] = W[w_addr][o][k];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [DL-1:0] qel(input int p, input int o);
        return q[(p*32+o)*DL +: DL];
    endfunction

    // Direct 3x3 convolution: each product truncated by >>>10, 32-bit running sum, then clamp.
    task automatic model();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                for (int o = 0; o < 32; o++) begin
                    int acc;
                    logic [31:0] tmp;
                    acc = 0;
                    for (int ch = 0; ch < 32; ch++)
                        for (int ky = 0; ky < 3; ky++)
                            for (int kx = 0; kx < 3; kx++) begin
                                longint prod;
                                prod = longint'($signed(D[ch][r+ky][c+kx])) *
                                       longint'($signed(W[ch][o][ky*3+kx]));
                                acc += int'(prod >>> 10);
                            end
                    tmp = acc;
                    if (acc > 131071)       exp_q[r*4+c][o] = 18'h1FFFF;
                    else if (acc < -131072) exp_q[r*4+c][o] = 18'h20000;
                    else                    exp_q[r*4+c][o] = tmp[17:0];
                end
    endtask

    task automatic do_fill(input string tag);
        int cyc;
        @(negedge clk);
        im_load = 1'b0; dot_load = 1'b0;
        @(negedge clk);
        im_load = 1'b1;
        cyc = 0;
        while (!im_valid && cyc < 1000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        chk({tag, "_fill_latency"}, cyc, 384);
        chk({tag, "_im_valid"}, {31'd0, im_valid}, 1);
    endtask

    task automatic do_dot(input string tag);
        int cyc;
        @(negedge clk);
        im_load = 1'b0; dot_load = 1'b0; cs = 4'd1;
        @(negedge clk);
        dot_load = 1'b1;
        cyc = 0;
        while (!dot_valid && cyc < 1000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        chk({tag, "_dot_latency"}, cyc, 387);
        model();
        for (int p = 0; p < 12; p++)
            for (int o = 0; o < 32; o++)
                chk($sformatf("%s_q_p%0d_o%0d", tag, p, o), {14'd0, qel(p, o)}, {14'd0, exp_q[p][o]});
        dot_load = 1'b0;
        @(negedge clk);
        chk({tag, "_dot_valid_drop"}, {31'd0, dot_valid}, 0);
        chk({tag, "_q_hold"}, {14'd0, qel(11, 31)}, {14'd0, exp_q[11][31]});
    endtask

    task automatic fill_w(input logic [DL-1:0] v);
        for (int ch = 0; ch < 32; ch++)
            for (int o = 0; o < 32; o++)
                for (int k = 0; k < 9; k++)
                    W[ch][o][k] = v;
    endtask

    task automatic rand_w();
        for (int ch = 0; ch < 32; ch++)
            for (int o = 0; o < 32; o++)
                for (int k = 0; k < 9; k++)
                    W[ch][o][k] = DL'($urandom_range(0, 262143));
    endtask

    initial begin
        bit seen;
        rst = 1'b1; im_load = 1'b0; dot_load = 1'b0; cs = 4'd0;
        for (int ch = 0; ch < 32; ch++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 6; x++)
                    D[ch][y][x] = 18'h00400;
        fill_w(18'h00040);
        repeat (3) @(negedge clk);
        chk("rst_im_valid", {31'd0, im_valid}, 0);
        chk("rst_dot_valid", {31'd0, dot_valid}, 0);
        chk("rst_w_addr", {27'd0, w_addr}, 0);
        chk("rst_q_zero", {31'd0, (q == '0)}, 1);
        rst = 1'b0;

        // All 1.0 data times 0.0625 weights: 288 * 0.0625 = 18.0.
        do_fill("t1");
        do_dot("t1");
        chk("t1_const", {14'd0, qel(0, 0)}, 32'h04800);

        fill_w(18'h00400);
        do_dot("t2");
        chk("t2_const", {14'd0, qel(6, 9)}, 32'h1FFFF);

        fill_w(18'h3FFC0);
        do_dot("t3");
        chk("t3_const", {14'd0, qel(3, 17)}, 32'h3B800);

        // Ramp data with centre-tap one-hot weights selects the window centre pixel.
        for (int ch = 0; ch < 32; ch++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 6; x++)
                    D[ch][y][x] = DL'(ch*30 + y*6 + x);
        for (int ch = 0; ch < 32; ch++)
            for (int o = 0; o < 32; o++)
                for (int k = 0; k < 9; k++)
                    W[ch][o][k] = (k == 4 && o == ch) ? 18'h00400 : 18'h00000;
        do_fill("t4");
        do_dot("t4");
        chk("t4_centre", {14'd0, qel(5, 7)}, 32'd224);

        for (int ch = 0; ch < 32; ch++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 6; x++)
                    D[ch][y][x] = DL'($urandom_range(0, 262143));
        rand_w();
        do_fill("t5");
        do_dot("t5");

        // A pass request with the idle layer code must do nothing.
        @(negedge clk);
        cs = 4'd0; dot_load = 1'b1; seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dot_valid) seen = 1'b1;
        end
        chk("t6_no_dot_valid", {31'd0, seen}, 0);
        for (int p = 0; p < 12; p += 5)
            for (int o = 0; o < 32; o += 7)
                chk($sformatf("t6_q_unchanged_p%0d_o%0d", p, o), {14'd0, qel(p, o)}, {14'd0, exp_q[p][o]});
        dot_load = 1'b0;

        // Reset in the middle of a fill, then let the fill restart from row 0.
        @(negedge clk);
        im_load = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_rst_im_valid", {31'd0, im_valid}, 0);
        chk("t7_rst_q_zero", {31'd0, (q == '0)}, 1);
        rst = 1'b0;
        begin
            int cyc;
            cyc = 0;
            while (!im_valid && cyc < 1000) begin
                @(posedge clk); cyc++;
                @(negedge clk);
            end
            chk("t7_refill_latency", cyc, 384);
        end
        rand_w();
        do_dot("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_dot_unit.md
# conv_dot_unit

First 3x3 convolution stage of the CNN datapath. It unrolls a 32-channel 5x6 feature map into 3x3 windows (im2col), buffers them in an on-chip window RAM, then multiplies every window against per-layer weights for 32 output channels. The result is a 12-position x 32-channel output map. It sits between the layer-sequencer (which drives `cs` and the load strobes) and the next layer's input buffer.

## Interface
- DATA_LEN, 18: element width, signed two's complement Q8.10
- FRAC, 10: fractional bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- im_load  in  1  level; high = run im2col fill
- d  in  32*5*6*DATA_LEN  feature map; element (ch,y,x) at index ch*30+y*6+x, LSB-first
- dot_load  in  1  level; high = run dot pass
- cs  in  4  layer code from sequencer; dot pass runs only when cs != LIDLE
- w_addr  out  5  input-channel index of weights needed
- w_data  in  32*9*DATA_LEN  weights for channel w_addr; (o,k) at index o*9+k; combinational from w_addr
- im_valid  out  1  fill complete
- dot_valid  out  1  dot pass complete
- q  out  12*32*DATA_LEN  result; (p,o) at index p*32+o

## Operation
- Window row address a = ch*12 + r*4 + c (ch 0..31, r 0..2, c 0..3); 384 rows used of 512.
- Row element k = ky*3+kx (LSB-first) = d[ch][r+ky][c+kx]; no padding, stride 1.
- Fill: while im_load high and im_valid low, write one row per cycle, a = 0..383 ascending; after a=383 write, im_valid=1 and writes stop.
- im_load low: fill counter -> 0, im_valid -> 0.
- Dot pass: ignored while im_load high. While dot_load high, cs != LIDLE, dot_valid low: read a = 0..383, one per cycle.
- For each returned row (ch,p): acc[p][o] += sum_k ((row[k]*w_data[o][k]) >>> FRAC), all 32 o in parallel (288 multipliers).
- Product 36-bit, arithmetic shift right FRAC (truncate toward -inf); accumulators 32-bit signed.
- At dot_valid, q[p][o] = acc saturated to DATA_LEN signed range (0x1FFFF / 0x20000).
- Rising edge of dot pass (idle -> run) clears all accumulators and q.
- dot_load low: read counter -> 0, dot_valid -> 0, q holds.
- Dot FSM: IDLE -> RUN (dot_load & cs!=LIDLE & !im_load) -> DRAIN (after a=383 issued, 2 cycles) -> DONE (dot_valid=1) -> IDLE when dot_load low.
- Re-asserting a load after DONE requires a low cycle first.

## Timing
- Reset: im_valid=0, dot_valid=0, q=0, w_addr=0, counters=0, FSM IDLE; RAM contents not reset.
- RAM: single port, synchronous write and synchronous read, 1-cycle read latency.
- Fill: first write on first clk edge with im_load high; im_valid high 384 cycles after im_load rises.
- Dot: address issued cycle t, ramout and registered w_addr = a/12 valid cycle t+1, accumulate at t+2.
- dot_valid high 387 cycles after pass starts.
- Reset mid-fill or mid-pass aborts immediately; the next run restarts from address 0.

## Structure
- Shared package: DATA_LEN, FRAC, layer codes (LIDLE=0, LAYER1=1, ...), geometry constants (32 ch, 5x6 in, 3x4 out, 384 rows).
- Sub-modules: `im2col` (fill counter + window mux), `window_ram` (512 x 9*DATA_LEN), `dot` (FSM + MAC array).
- Top-level muxes the RAM address: im2col when im_load, else dot.

## Test plan
- d all 1.0 (0x00400), w_data all 0.0625 (0x00040), im_load 384+ cycles then dot_load -> im_valid at cycle 384; every q = 18.0 (0x04800) at dot_valid.
- Same d, w all 1.0 -> sum 288.0 overflows; every q = 0x1FFFF.
- d ramp (element = index*2^-10), w one-hot k=4, o=ch -> q[p][o] = centre pixel of window p, channel o.
- w negative (-0.0625) -> q = -18.0 (0x3B800 in 18 bits).
- Assert rst mid-fill at row 100 -> im_valid=0; refill completes at 384 cycles from restart.
- dot_load with cs=LIDLE -> no reads, dot_valid stays 0, q unchanged.
